// File: rtl/trigger_conditioner_if.sv
// Downstream side of the trigger conditioner: the clean pulse and level, the
// holdoff indicator and the drop counter face the timestamp latch. busy and
// drop_clr come back from it.
interface trigger_conditioner_if #(
  parameter int DROP_CNT_WIDTH = 8
);
  logic                      trig_pulse;
  logic                      trig_level;
  logic                      holdoff_active;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt;
  logic                      busy;
  logic                      drop_clr;

  modport master (
    output trig_pulse, trig_level, holdoff_active, drop_cnt,
    input  busy, drop_clr
  );

  modport slave (
    input  trig_pulse, trig_level, holdoff_active, drop_cnt,
    output busy, drop_clr
  );
endinterface

// File: rtl/trigger_conditioner.sv
// trigger_conditioner: synchronises a raw trigger pin, normalises polarity,
// digitally filters level changes and emits one registered pulse per
// qualified event, with a holdoff dead time and a qualified release.
// Optional feature macro: TRIGGER_CONDITIONER_DROP_CNT_EN compiles in a
// saturating counter of events that qualified while the latch was busy.
module trigger_conditioner #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILT_WIDTH     = 4,
  parameter int HOLDOFF_WIDTH  = 8,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     trig_in,
  input  logic                     polarity,
  input  logic [FILT_WIDTH-1:0]    filt_len,
  input  logic [HOLDOFF_WIDTH-1:0] holdoff,
  trigger_conditioner_if.master    bus
);

  typedef enum logic [1:0] {IDLE, QUALIFY, HOLDOFF, WAIT_RELEASE} state_t;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     pol_q;
  logic [FILT_WIDTH-1:0]    filt_q;
  logic [HOLDOFF_WIDTH-1:0] hold_q;
  logic [FILT_WIDTH-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [HOLDOFF_WIDTH-1:0] hcnt_q, hcnt_d;
  logic                     level_q, level_d;
  logic                     pulse_q, hact_q;
  logic                     qual, drop;

  // In IDLE the live configuration is used directly; the registered copy
  // captured on the leaving edge then holds it for the rest of the event.
  logic                     in_idle;
  logic                     pol_e;
  logic [FILT_WIDTH-1:0]    filt_e, feff;
  logic [HOLDOFF_WIDTH-1:0] hold_e;
  logic                     s;

  assign in_idle = (state_q == IDLE);
  assign pol_e   = in_idle ? polarity : pol_q;
  assign filt_e  = in_idle ? filt_len : filt_q;
  assign hold_e  = in_idle ? holdoff  : hold_q;
  assign feff    = (filt_e == '0) ? FILT_WIDTH'(1) : filt_e;
  assign s       = ~(sync_q[SYNC_STAGES-1] ^ pol_e);
  assign cnt_inc = cnt_q + FILT_WIDTH'(1);

  // Metastability synchroniser for the asynchronous pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], trig_in};
  end

  // Configuration snapshot, tracking the inputs only while IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pol_q  <= 1'b0;
      filt_q <= '0;
      hold_q <= '0;
    end else if (in_idle) begin
      pol_q  <= polarity;
      filt_q <= filt_len;
      hold_q <= holdoff;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      hact_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      level_q <= level_d;
      pulse_q <= qual & ~bus.busy;
      hact_q  <= (state_d == HOLDOFF);
    end
  end

  // Next state: qualify / holdoff / release. cnt is the qualify count in
  // QUALIFY and the release count in WAIT_RELEASE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    level_d = level_q;
    qual    = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          if (feff == FILT_WIDTH'(1)) begin
            qual = 1'b1;
          end else begin
            state_d = QUALIFY;
            cnt_d   = FILT_WIDTH'(1);
          end
        end
      end
      QUALIFY: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_inc == feff) begin
          qual = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HOLDOFF: begin
        if (hcnt_q <= HOLDOFF_WIDTH'(1)) begin
          state_d = WAIT_RELEASE;
          cnt_d   = '0;
          hcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_q - HOLDOFF_WIDTH'(1);
        end
      end
      WAIT_RELEASE: begin
        if (s) begin
          cnt_d = '0;
        end else if (cnt_inc == feff) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (qual) begin
      level_d = 1'b1;
      cnt_d   = '0;
      if (hold_e != '0) begin
        state_d = HOLDOFF;
        hcnt_d  = hold_e;
      end else begin
        state_d = WAIT_RELEASE;
      end
    end
  end

  assign drop               = qual & bus.busy;
  assign bus.trig_pulse     = pulse_q;
  assign bus.trig_level     = level_q;
  assign bus.holdoff_active = hact_q;

`ifdef TRIGGER_CONDITIONER_DROP_CNT_EN
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;

  // Saturating drop counter; a clear coinciding with a drop leaves 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     drop_cnt_q <= '0;
    else if (bus.drop_clr)          drop_cnt_q <= drop ? DROP_CNT_WIDTH'(1) : '0;
    else if (drop && ~&drop_cnt_q)  drop_cnt_q <= drop_cnt_q + DROP_CNT_WIDTH'(1);
  end

  assign bus.drop_cnt = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop  = ^{bus.drop_clr, drop};
  assign bus.drop_cnt = '0;
`endif

endmodule

// File: doc/trigger_conditioner.md
TRIGGER_CONDITIONER -- requirements
Module: trigger_conditioner

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth (>=2).
REQ-002 SHALL have parameter FILT_WIDTH, default 4, width of filt_len.
REQ-003 SHALL have parameter HOLDOFF_WIDTH, default 8, width of holdoff.
REQ-004 SHALL have parameter DROP_CNT_WIDTH, default 8, width of drop_cnt.
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port trig_in  input  1  raw asynchronous trigger pin.
REQ-008 SHALL have port polarity  input  1  1 = high is active, 0 = low is active.
REQ-009 SHALL have port filt_len  input  FILT_WIDTH  consecutive samples required to qualify a level change; 0 treated as 1.
REQ-010 SHALL have port holdoff  input  HOLDOFF_WIDTH  dead-time cycles after an accepted event.
REQ-011 SHALL have port busy  input  1  downstream timestamp latch cannot accept an event.
REQ-012 SHALL have port drop_clr  input  1  synchronous clear of drop_cnt.
REQ-013 SHALL have port trig_pulse  output  1  one-cycle clean trigger to the timestamp latcher.
REQ-014 SHALL have port trig_level  output  1  filtered, polarity-normalised trigger level.
REQ-015 SHALL have port holdoff_active  output  1  high while in HOLDOFF.
REQ-016 SHALL have port drop_cnt  output  DROP_CNT_WIDTH  count of events qualified while busy.

Function
REQ-017 SHALL pass trig_in through SYNC_STAGES flops; sample s = sync_out XNOR polarity (1 = active).
REQ-018 SHALL register polarity, filt_len and holdoff only while in IDLE; values are frozen in all other states.
REQ-019 SHALL implement states IDLE, QUALIFY, HOLDOFF, WAIT_RELEASE with a qualify counter and a holdoff counter.
REQ-020 IDLE: s=1 -> QUALIFY with count 1; if effective filt_len = 1, qualify immediately (REQ-022).
REQ-021 QUALIFY: s=1 increments count; s=0 -> IDLE, count cleared, no event.
REQ-022 On count reaching effective filt_len: event qualified; trig_level <= 1; next state HOLDOFF if holdoff != 0, else WAIT_RELEASE.
REQ-023 Qualified event with busy=0 (sampled in qualifying cycle) SHALL assert registered trig_pulse for exactly one cycle; with busy=1, no pulse and drop recorded.
REQ-024 Latency: trig_in held active from first sampling edge t0 -> trig_pulse high in the cycle after edge t0 + SYNC_STAGES + effective filt_len - 1.
REQ-025 HOLDOFF: lasts exactly holdoff cycles starting the cycle after qualification; all sample activity ignored; then -> WAIT_RELEASE.
REQ-026 WAIT_RELEASE: requires effective filt_len consecutive s=0 samples -> IDLE with trig_level <= 0; any s=1 restarts the release count.
REQ-027 Level held active forever SHALL produce exactly one pulse; a new pulse needs a qualified release first.
REQ-028 trig_pulse and holdoff_active SHALL be registered outputs, glitch-free.
REQ-029 drop_cnt SHALL saturate at all-ones; drop_clr and a simultaneous drop in the same cycle yields drop_cnt = 1.

Reset
REQ-030 rst_n low SHALL asynchronously force state IDLE, synchronizer flops and counters to 0, trig_pulse=0, trig_level=0, holdoff_active=0, drop_cnt=0.
REQ-031 Reset asserted mid-QUALIFY or mid-HOLDOFF SHALL abort with no pulse; after release, an already-active trig_in qualifies afresh from IDLE.

Configuration
REQ-032 With TRIGGER_CONDITIONER_DROP_CNT_EN defined, drop counting per REQ-023/REQ-029 SHALL be compiled in.
REQ-033 Without TRIGGER_CONDITIONER_DROP_CNT_EN, drop_cnt SHALL be constant 0, drop_clr ignored, no counter flops; busy still suppresses pulses.

Verification
REQ-034 polarity=1, filt_len=3, holdoff=0, trig_in 0->1 held 20 cycles -> single trig_pulse at edge t0+4 (SYNC_STAGES=2), trig_level=1.
REQ-035 filt_len=4, trig_in high 3 cycles then low -> no trig_pulse, trig_level stays 0, state returns IDLE.
REQ-036 holdoff=10, filt_len=1, trig_in pulses every 4 cycles for 40 cycles -> pulses only after each holdoff+release completes; holdoff_active high exactly 10 cycles per event.
REQ-037 busy=1 during 3 qualified events, then drop_clr -> no trig_pulse, drop_cnt 3 then 0; 300 dropped events with width 8 -> drop_cnt=255.
REQ-038 polarity=0, trig_in idle high, 1->0 held -> one pulse; polarity toggled mid-HOLDOFF -> no effect until IDLE.
REQ-039 rst_n asserted during QUALIFY with trig_in high, released -> no pulse during reset, one pulse SYNC_STAGES+filt_len cycles after release.
